pwm_phase_sequencer: RTL and testbench
======================================

# pwm_phase_sequencer

Sequences the three duty-cycle inputs of the three-phase centre-aligned PWM generator. On every PWM period sync pulse it advances a 16-bit electrical phase accumulator, ramps the drive amplitude toward its target, and reads one shared quarter-wave sine LUT port three times, once per phase. It then publishes all three 10-bit duties together. It sits between the motor-control registers and the PWM block; its A/B/C outputs drive the PWM A/B/C inputs.

## Interface
- LUT_LATENCY, 1, sine LUT read latency in cycles; only 1 is supported.
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Sync  in  1  one-cycle pulse from PWM Sync_Out, once per PWM period.
- Enable  in  1  1 = run sequence; 0 = park outputs at 50 %.
- Step  in  16  phase increment per PWM period; sampled only at an accepted Sync.
- Amp_Target  in  10  target amplitude, 0..1023 (1024 = unity).
- Ramp_Step  in  8  amplitude change per PWM period (soft-start only).
- Lut_Addr  out  8  quarter-wave sine LUT address, registered.
- Lut_Data  in  9  LUT magnitude 0..511; valid one cycle after Lut_Addr.
- A, B, C  out  10  duty values for the PWM block, registered.
- Update  out  1  one-cycle pulse, high in the cycle after A/B/C change.
- Busy  out  1  high while a LUT sequence is in progress.
- Overrun  out  1  sticky: a Sync arrived while Busy; cleared while Enable = 0.

## Operation
- The state machine has five states: IDLE, RD_A, RD_B, RD_C, WAIT_C.
- **IDLE, Sync = 1, Enable = 1:**
  - acc <= acc + Step (mod 2^16).
  - Amp_Cur <= ramped value.
  - Lut_Addr <= index of phase A.
  - Go to RD_A.
- **IDLE, Sync = 1, Enable = 0:**
  - A, B, C <= 512; Update pulses.
  - acc holds; Amp_Cur <= 0.
  - Overrun <= 0.
- **Sequence:**
  - RD_A → RD_B: Lut_Addr <= B index.
  - RD_B → RD_C: capture phase A into staging; Lut_Addr <= C index.
  - RD_C → WAIT_C: capture phase B into staging.
  - WAIT_C → IDLE: compute C; load A, B, C outputs together; Update pulses.
- **Angles**, each the top 10 bits of a 16-bit sum:
  - A = acc.
  - B = acc - 0x5555.
  - C = acc + 0x5555.
- **LUT index:**
  - quadrant q = angle[9:8]; index = angle[7:0], bitwise-inverted when q is odd.
  - Sign is negative when q[1] = 1.
- **Duty arithmetic:**
  - mag = (Lut_Data × Amp_Cur) >> 10, truncated; 19-bit product, mag ≤ 510.
  - duty = 512 + mag (positive) or 512 - mag (negative).
  - No clamping is needed; the result is always within 2..1022.
  - A single multiplier is shared across the three captures.
- **Ramp:**
  - If Amp_Cur < Amp_Target: Amp_Cur <= min(Amp_Cur + Ramp_Step, Amp_Target).
  - If Amp_Cur > Amp_Target: Amp_Cur <= max(Amp_Cur - Ramp_Step, Amp_Target).
  - The ramp uses 11-bit intermediates, so there is no wrap.
- A Sync while Busy is ignored (no restart, acc unchanged) and sets Overrun.
- Enable falling mid-sequence: the sequence completes normally. The Enable = 0 behaviour applies at the next Sync.
- Reset asserted mid-sequence aborts it immediately; no Update is issued.

## Timing
- Reset values:
  - A = B = C = 512, Lut_Addr = 0.
  - Update = 0, Busy = 0, Overrun = 0.
  - acc = 0, Amp_Cur = 0, state IDLE.
- Sync sampled at edge n:
  - Lut_Addr shows the A, B, C indices in cycles n+1, n+2 and n+3.
  - Outputs change at edge n+4; Update is high in cycle n+5.
- Busy is high in cycles n+1..n+4.
- The disabled path updates outputs at edge n; Update is high in cycle n+1.
- Minimum Sync spacing is 5 cycles. The PWM period is 2046 cycles, so overrun indicates a fault.

## Configuration
- PWM_SOFT_START_EN defined: Amp_Cur ramps by Ramp_Step as above, and is forced to 0 whenever Enable = 0 at a Sync.
- Not defined:
  - Amp_Cur <= Amp_Target at every accepted Sync.
  - Ramp_Step is unused.
  - Enable = 0 still parks outputs at 512.

## Test plan
- Reset release, no Sync → A = B = C = 512, Update = 0, Busy = 0, Lut_Addr = 0.
- Step = 0, Amp_Target = 1023, LUT model returns 400, soft-start off, Enable = 1, Sync at n → Lut_Addr = 0x00, 0xAA, 0xAA in n+1..n+3; A = 911, B = 113, C = 911 at n+4; Update high at n+5.
- Step = 0x4000, Sync repeated → acc advances by 0x4000 per Sync; phase-A quadrant cycles 1, 2, 3, 0 with index 0xFF, 0x00, 0xFF, 0x00.
- Soft-start on, Amp_Target = 100, Ramp_Step = 30 → Amp_Cur = 30, 60, 90, 100, 100 on successive Syncs; then Enable = 0 at Sync → outputs 512, Amp_Cur = 0.
- Second Sync 2 cycles after the first → Overrun = 1, single Update, acc advanced once; Enable = 0 at the next Sync → Overrun = 0.
- Reset asserted in RD_B → outputs 512 immediately, no Update pulse, Busy = 0.

Source files
------------

// File: rtl/pwm_phase_sequencer_if.sv
// Sine LUT read port and three-phase PWM duty bus of the phase sequencer.
// The sequencer drives the master side; the LUT and the PWM block sit on the slave side.
interface pwm_phase_sequencer_if;
  logic [7:0] lut_addr;
  logic [8:0] lut_data;
  logic [9:0] duty_a;
  logic [9:0] duty_b;
  logic [9:0] duty_c;
  logic       update;

  modport master (
    output lut_addr,
    input  lut_data,
    output duty_a,
    output duty_b,
    output duty_c,
    output update
  );

  modport slave (
    input  lut_addr,
    output lut_data,
    input  duty_a,
    input  duty_b,
    input  duty_c,
    input  update
  );
endinterface

// File: rtl/pwm_phase_sequencer.sv
// Three-phase duty sequencer: phase accumulator, amplitude ramp and a shared quarter-wave LUT read.
// Define PWM_SOFT_START_EN to ramp the amplitude by i_ramp_step per period instead of jumping to target.
module pwm_phase_sequencer #(
  parameter int LUT_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_sync,
  input  logic                  i_enable,
  input  logic [15:0]           i_step,
  input  logic [9:0]            i_amp_target,
  input  logic [7:0]            i_ramp_step,
  output logic                  o_busy,
  output logic                  o_overrun,
  output logic [2:0]            o_state,
  pwm_phase_sequencer_if.master bus
);

  generate
    if (LUT_LATENCY != 1) begin : g_lut_latency_check
      $error("pwm_phase_sequencer: only LUT_LATENCY = 1 is supported");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_A   = 3'd1,
    ST_RD_B   = 3'd2,
    ST_RD_C   = 3'd3,
    ST_WAIT_C = 3'd4
  } state_t;

  localparam logic [15:0] PHASE_120 = 16'h5555;
  localparam logic [9:0]  DUTY_MID  = 10'd512;

  state_t      r_state;
  logic [15:0] r_acc;
  logic [9:0]  r_amp_cur;
  logic [7:0]  r_lut_addr;
  logic [9:0]  r_stage_a;
  logic [9:0]  r_stage_b;
  logic [9:0]  r_duty_a;
  logic [9:0]  r_duty_b;
  logic [9:0]  r_duty_c;
  logic        r_update;
  logic        r_busy;
  logic        r_overrun;

  logic [15:0] w_acc_next;
  logic [9:0]  w_ang_a;
  logic [9:0]  w_ang_b;
  logic [9:0]  w_ang_c;
  logic [7:0]  w_idx_next;
  logic [9:0]  w_amp_next;
  logic [18:0] w_prod;
  logic [8:0]  w_mag;
  logic        w_neg;
  logic [9:0]  w_duty;

  // Quarter-wave folding: odd quadrants read the table backwards.
  function automatic logic [7:0] lut_index(input logic [8:0] qi);
    return qi[8] ? ~qi[7:0] : qi[7:0];
  endfunction

  assign w_acc_next = r_acc + i_step;
  assign w_ang_a    = r_acc[15:6];
  assign w_ang_b    = 10'((r_acc - PHASE_120) >> 6);
  assign w_ang_c    = 10'((r_acc + PHASE_120) >> 6);
  assign w_idx_next = lut_index(w_acc_next[14:6]);

`ifdef PWM_SOFT_START_EN
  logic [10:0] w_ramp_up;
  logic [10:0] w_ramp_floor;

  // 11-bit intermediates keep the up/down steps from wrapping around 0 or 1023.
  always_comb begin
    w_amp_next   = r_amp_cur;
    w_ramp_up    = {1'b0, r_amp_cur} + {3'b000, i_ramp_step};
    w_ramp_floor = {1'b0, i_amp_target} + {3'b000, i_ramp_step};
    if (r_amp_cur < i_amp_target) begin
      w_amp_next = (w_ramp_up > {1'b0, i_amp_target}) ? i_amp_target : w_ramp_up[9:0];
    end else if (r_amp_cur > i_amp_target) begin
      w_amp_next = ({1'b0, r_amp_cur} > w_ramp_floor) ?
                   (r_amp_cur - {2'b00, i_ramp_step}) : i_amp_target;
    end
  end
`else
  logic w_unused_ramp_step;
  assign w_unused_ramp_step = ^i_ramp_step;
  assign w_amp_next         = i_amp_target;
`endif

  // One multiplier serves all three phases; the state picks whose sign applies.
  assign w_prod = {10'd0, bus.lut_data} * {9'd0, r_amp_cur};
  assign w_mag  = 9'(w_prod >> 10);

  always_comb begin
    w_neg = w_ang_c[9];
    case (r_state)
      ST_RD_B: w_neg = w_ang_a[9];
      ST_RD_C: w_neg = w_ang_b[9];
      default: w_neg = w_ang_c[9];
    endcase
  end

  assign w_duty = w_neg ? (DUTY_MID - {1'b0, w_mag}) : (DUTY_MID + {1'b0, w_mag});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_acc      <= '0;
      r_amp_cur  <= '0;
      r_lut_addr <= '0;
      r_stage_a  <= DUTY_MID;
      r_stage_b  <= DUTY_MID;
      r_duty_a   <= DUTY_MID;
      r_duty_b   <= DUTY_MID;
      r_duty_c   <= DUTY_MID;
      r_update   <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_update <= 1'b0;

      if (i_sync && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end else if (!i_enable) begin
        r_overrun <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (i_sync) begin
            if (i_enable) begin
              r_acc      <= w_acc_next;
              r_amp_cur  <= w_amp_next;
              r_lut_addr <= w_idx_next;
              r_busy     <= 1'b1;
              r_state    <= ST_RD_A;
            end else begin
              r_duty_a  <= DUTY_MID;
              r_duty_b  <= DUTY_MID;
              r_duty_c  <= DUTY_MID;
              r_update  <= 1'b1;
              r_amp_cur <= '0;
            end
          end
        end
        ST_RD_A: begin
          r_lut_addr <= lut_index(w_ang_b[8:0]);
          r_state    <= ST_RD_B;
        end
        ST_RD_B: begin
          r_stage_a  <= w_duty;
          r_lut_addr <= lut_index(w_ang_c[8:0]);
          r_state    <= ST_RD_C;
        end
        ST_RD_C: begin
          r_stage_b <= w_duty;
          r_state   <= ST_WAIT_C;
        end
        ST_WAIT_C: begin
          r_duty_a <= r_stage_a;
          r_duty_b <= r_stage_b;
          r_duty_c <= w_duty;
          r_update <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.lut_addr = r_lut_addr;
  assign bus.duty_a   = r_duty_a;
  assign bus.duty_b   = r_duty_b;
  assign bus.duty_c   = r_duty_c;
  assign bus.update   = r_update;
  assign o_busy       = r_busy;
  assign o_overrun    = r_overrun;
  assign o_state      = r_state;

endmodule

// File: tb/tb_pwm_phase_sequencer.sv
// Directed self-checking bench for pwm_phase_sequencer; expectations are hand-computed.
// Builds with or without PWM_SOFT_START_EN; only the ramp expectations differ.
module tb_pwm_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sync = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] step = 16'd0;
  logic [9:0]  amp_target = 10'd0;
  logic [7:0]  ramp_step = 8'd0;
  logic        busy;
  logic        overrun;
  logic [2:0]  state;
  logic        lut_mode = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int upd_cnt = 0;
  int u0;

  logic [29:0] exp_q[$];
  logic [9:0]  ramp_a[5];
  logic [9:0]  ramp_b[5];

  pwm_phase_sequencer_if bus();

  pwm_phase_sequencer #(.LUT_LATENCY(1)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_sync       (sync),
    .i_enable     (enable),
    .i_step       (step),
    .i_amp_target (amp_target),
    .i_ramp_step  (ramp_step),
    .o_busy       (busy),
    .o_overrun    (overrun),
    .o_state      (state),
    .bus          (bus.master)
  );

  // clock / reset
  always #5 clk = ~clk;

  // LUT model: mode 0 returns 400, mode 1 returns 2*addr; one cycle latency
  always @(posedge clk) bus.lut_data <= lut_mode ? {bus.lut_addr, 1'b0} : 9'd400;

  always @(posedge clk) if (bus.update === 1'b1) upd_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Full enabled sequence with addresses and duties checked cycle by cycle.
  task automatic run_seq(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                         input logic [7:0] ic, input logic [9:0] da, input logic [9:0] db,
                         input logic [9:0] dc);
    logic [29:0] e;
    exp_q.push_back({da, db, dc});
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk({tag, ".addr_a"}, bus.lut_addr, ia);
    chk({tag, ".busy1"}, busy, 1);
    tick();
    chk({tag, ".addr_b"}, bus.lut_addr, ib);
    tick();
    chk({tag, ".addr_c"}, bus.lut_addr, ic);
    tick();
    chk({tag, ".upd_early"}, bus.update, 0);
    chk({tag, ".busy4"}, busy, 1);
    tick();
    e = exp_q.pop_front();
    chk({tag, ".duty_a"}, bus.duty_a, e[29:20]);
    chk({tag, ".duty_b"}, bus.duty_b, e[19:10]);
    chk({tag, ".duty_c"}, bus.duty_c, e[9:0]);
    chk({tag, ".upd"}, bus.update, 1);
    chk({tag, ".busy_done"}, busy, 0);
    tick();
    chk({tag, ".upd_end"}, bus.update, 0);
  endtask

  task automatic disabled_sync(input string tag);
    enable = 1'b0;
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk({tag, ".duty_a"}, bus.duty_a, 512);
    chk({tag, ".duty_b"}, bus.duty_b, 512);
    chk({tag, ".duty_c"}, bus.duty_c, 512);
    chk({tag, ".upd"}, bus.update, 1);
    chk({tag, ".busy"}, busy, 0);
    tick();
    chk({tag, ".upd_end"}, bus.update, 0);
  endtask

  task automatic plain_sync();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
`ifdef PWM_SOFT_START_EN
    ramp_a = '{10'd523, 10'd535, 10'd547, 10'd551, 10'd551};
    ramp_b = '{10'd501, 10'd489, 10'd477, 10'd473, 10'd473};
`else
    ramp_a = '{10'd551, 10'd551, 10'd551, 10'd551, 10'd551};
    ramp_b = '{10'd473, 10'd473, 10'd473, 10'd473, 10'd473};
`endif

    // reset values, during and after reset
    repeat (2) tick();
    chk("rst.duty_a", bus.duty_a, 512);
    chk("rst.addr", bus.lut_addr, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle.duty_a", bus.duty_a, 512);
    chk("idle.duty_b", bus.duty_b, 512);
    chk("idle.duty_c", bus.duty_c, 512);
    chk("idle.update", bus.update, 0);
    chk("idle.busy", busy, 0);
    chk("idle.overrun", overrun, 0);
    chk("idle.addr", bus.lut_addr, 0);
    chk("idle.state", state, 0);

    // basic sequence: step 0, full amplitude, LUT = 400
    enable = 1'b1;
    step = 16'h0000;
    amp_target = 10'd1023;
`ifdef PWM_SOFT_START_EN
    ramp_step = 8'd255;
    repeat (4) plain_sync();
`endif
    run_seq("basic", 8'h00, 8'hAA, 8'hAA, 10'd911, 10'd113, 10'd911);

    // quadrant walk: step 0x4000, LUT = 2*addr
    lut_mode = 1'b1;
    step = 16'h4000;
    run_seq("q1", 8'hFF, 8'h55, 8'h55, 10'd1021, 10'd343, 10'd343);
    run_seq("q2", 8'h00, 8'hAA, 8'hAA, 10'd512, 10'd851, 10'd173);
    run_seq("q3", 8'hFF, 8'h55, 8'h55, 10'd3, 10'd681, 10'd681);
    run_seq("q0", 8'h00, 8'hAA, 8'hAA, 10'd512, 10'd173, 10'd851);

    // amplitude ramp from a parked start
    lut_mode = 1'b0;
    step = 16'h0000;
    amp_target = 10'd100;
    ramp_step = 8'd30;
    disabled_sync("park0");
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_seq($sformatf("ramp%0d", i), 8'h00, 8'hAA, 8'hAA, ramp_a[i], ramp_b[i], ramp_a[i]);
    end
    disabled_sync("park1");
    enable = 1'b1;
    run_seq("ramp_restart", 8'h00, 8'hAA, 8'hAA, ramp_a[0], ramp_b[0], ramp_a[0]);

    // overrun: second Sync two cycles after the first
    step = 16'h4000;
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk("ovr.addr_a", bus.lut_addr, 8'hFF);
    u0 = upd_cnt;
    tick();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk("ovr.flag", overrun, 1);
    chk("ovr.addr_c", bus.lut_addr, 8'h55);
    repeat (6) tick();
    chk("ovr.one_update", upd_cnt - u0, 1);
    chk("ovr.sticky", overrun, 1);
    disabled_sync("ovr_park");
    chk("ovr.cleared", overrun, 0);
    enable = 1'b1;
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk("ovr.acc_once", bus.lut_addr, 8'h00);
    repeat (6) tick();

    // reset asserted while in RD_B
    sync = 1'b1;
    tick();
    sync = 1'b0;
    tick();
    chk("rstmid.state", state, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid.duty_a", bus.duty_a, 512);
    chk("rstmid.duty_b", bus.duty_b, 512);
    chk("rstmid.duty_c", bus.duty_c, 512);
    chk("rstmid.busy", busy, 0);
    chk("rstmid.state_idle", state, 0);
    u0 = upd_cnt;
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("rstmid.no_update", upd_cnt - u0, 0);
    chk("rstmid.duty_hold", bus.duty_a, 512);
    chk("rstmid.busy_after", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
